// File: rtl/io_bus_responder_if.sv
// rtl/io_bus_responder_if.sv - IO-space bus strobes, address and data between CPU datapath and responder
interface io_bus_responder_if;
  logic        ioread;
  logic        iowrite;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output ioread,
    output iowrite,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  ioread,
    input  iowrite,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/io_bus_responder.sv
// rtl/io_bus_responder.sv - IO responder: LED register, synchronized switches, optional timer (IO_TIMER_EN)
module io_bus_responder #(
  parameter int PRESCALE = 100,
  parameter int SW_W     = 24
) (
  input  logic                clock,
  input  logic                reset,
  io_bus_responder_if.slave   bus,
  input  logic [SW_W-1:0]     switch_i,
  output logic [SW_W-1:0]     led_o,
  output logic                timer_irq
);

  localparam logic [7:0] A_TCTRL  = 8'h08;
  localparam logic [7:0] A_TCOUNT = 8'h09;
  localparam logic [7:0] A_TSTAT  = 8'h0A;
  localparam logic [7:0] A_LED    = 8'h18;
  localparam logic [7:0] A_SWITCH = 8'h1C;

  logic [7:0]      word_addr;
  logic            wr_led;
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic            unused_bits;

  assign word_addr   = bus.addr[9:2];
  assign wr_led      = bus.iowrite && (word_addr == A_LED);
  assign unused_bits = &{1'b0, bus.addr[1:0], bus.wdata};

  always_ff @(posedge clock) begin
    if (reset) begin
      led_o   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_i;
      sw_sync <= sw_meta;
      if (wr_led)
        led_o <= bus.wdata[SW_W-1:0];
    end
  end

`ifdef IO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic          en;
  logic          auto_rl;
  logic          expired;
  logic [15:0]   reload;
  logic [15:0]   count;
  logic [PW-1:0] presc;
  logic          wr_tctrl;
  logic          wr_tcount;
  logic          rd_tstat;
  logic          tick;
  logic          tick_eff;

  assign wr_tctrl  = bus.iowrite && (word_addr == A_TCTRL);
  assign wr_tcount = bus.iowrite && (word_addr == A_TCOUNT);
  assign rd_tstat  = bus.ioread  && (word_addr == A_TSTAT);
  assign tick      = en && (presc == PRESC_LAST);
  // A TCOUNT load or a TCTRL write disabling the timer swallows this tick's count effect.
  assign tick_eff  = tick && !wr_tcount && !(wr_tctrl && !bus.wdata[0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      expired <= 1'b0;
      reload  <= '0;
      count   <= '0;
      presc   <= '0;
    end else begin
      if (wr_tctrl || !en || tick)
        presc <= '0;
      else
        presc <= presc + PW'(1);

      if (rd_tstat)
        expired <= 1'b0;

      // Set is ordered after the read-clear so a coincident expiry wins.
      if (tick_eff) begin
        if (count > 16'd1) begin
          count <= count - 16'd1;
        end else begin
          expired <= 1'b1;
          if (auto_rl) begin
            count <= reload;
          end else begin
            count <= '0;
            en    <= 1'b0;
          end
        end
      end

      if (wr_tcount) begin
        reload <= bus.wdata[15:0];
        count  <= bus.wdata[15:0];
      end

      if (wr_tctrl) begin
        en      <= bus.wdata[0];
        auto_rl <= bus.wdata[1];
      end
    end
  end

  assign timer_irq = expired;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    bus.rdata = '0;
    if (bus.ioread) begin
      case (word_addr)
        A_LED:    bus.rdata = 32'(led_o);
        A_SWITCH: bus.rdata = 32'(sw_sync);
`ifdef IO_TIMER_EN
        A_TCTRL:  bus.rdata = {30'd0, auto_rl, en};
        A_TCOUNT: bus.rdata = {16'd0, count};
        A_TSTAT:  bus.rdata = {31'd0, expired};
`endif
        default:  bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// tb/tb_io_bus_responder.sv - table-driven and sequence checks of io_bus_responder with a read scoreboard
module tb_io_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] switch_i;
  logic [23:0] led_o;
  logic        timer_irq;

  io_bus_responder_if bus ();

  io_bus_responder #(.PRESCALE(4), .SW_W(24)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .switch_i  (switch_i),
    .led_o     (led_o),
    .timer_irq (timer_irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [23:0] sw;
    logic [31:0] exp_rdata;
    logic [23:0] exp_led;
  } vec_t;

  vec_t        vecs [17];
  logic [31:0] sb_q [$];
  int          n_pass = 0;
  int          n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ioread  = 1'b0;
    bus.iowrite = 1'b0;
    repeat (n) step();
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string name);
    bus.ioread = 1'b1;
    bus.addr   = a;
    sb_q.push_back(exp);
    #3;
    chk(name, bus.rdata, sb_q.pop_front());
    step();
    bus.ioread = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus.iowrite = 1'b1;
    bus.addr    = a;
    bus.wdata   = d;
    step();
    bus.iowrite = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 10'h060, 32'h0,        24'h0,      32'h0,        24'h0};
    vecs[1]  = '{1'b1, 1'b0, 10'h070, 32'h0,        24'h0,      32'h0,        24'h0};
    vecs[2]  = '{1'b0, 1'b1, 10'h060, 32'h00A5A5A5, 24'h0,      32'h0,        24'hA5A5A5};
    vecs[3]  = '{1'b1, 1'b0, 10'h060, 32'h0,        24'h0,      32'h00A5A5A5, 24'hA5A5A5};
    vecs[4]  = '{1'b1, 1'b1, 10'h060, 32'h005A5A5A, 24'h0,      32'h00A5A5A5, 24'h5A5A5A};
    vecs[5]  = '{1'b0, 1'b1, 10'h070, 32'hFFFFFFFF, 24'h0,      32'h0,        24'h5A5A5A};
    vecs[6]  = '{1'b1, 1'b0, 10'h3FC, 32'h0,        24'h0,      32'h0,        24'h5A5A5A};
    vecs[7]  = '{1'b0, 1'b1, 10'h3FC, 32'hFFFFFFFF, 24'h0,      32'h0,        24'h5A5A5A};
    vecs[8]  = '{1'b1, 1'b0, 10'h062, 32'h0,        24'h0,      32'h005A5A5A, 24'h5A5A5A};
    vecs[9]  = '{1'b0, 1'b1, 10'h060, 32'hFF123456, 24'h0,      32'h0,        24'h123456};
    vecs[10] = '{1'b1, 1'b0, 10'h064, 32'h0,        24'h0,      32'h0,        24'h123456};
    vecs[11] = '{1'b1, 1'b0, 10'h070, 32'h0,        24'h123456, 32'h0,        24'h123456};
    vecs[12] = '{1'b1, 1'b0, 10'h070, 32'h0,        24'h123456, 32'h0,        24'h123456};
    vecs[13] = '{1'b1, 1'b0, 10'h070, 32'h0,        24'h123456, 32'h00123456, 24'h123456};
    vecs[14] = '{1'b1, 1'b0, 10'h070, 32'h0,        24'hFFFFFF, 32'h00123456, 24'h123456};
    vecs[15] = '{1'b1, 1'b0, 10'h070, 32'h0,        24'hFFFFFF, 32'h00123456, 24'h123456};
    vecs[16] = '{1'b1, 1'b0, 10'h070, 32'h0,        24'hFFFFFF, 32'h00FFFFFF, 24'h123456};

    reset       = 1'b1;
    switch_i    = '0;
    bus.ioread  = 1'b0;
    bus.iowrite = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    repeat (2) step();
    reset = 1'b0;
    chk("reset led_o", 32'(led_o), 32'h0);
    chk("reset timer_irq", 32'(timer_irq), 32'h0);

    for (int i = 0; i < 17; i++) begin
      switch_i    = vecs[i].sw;
      bus.ioread  = vecs[i].rd;
      bus.iowrite = vecs[i].wr;
      bus.addr    = vecs[i].addr;
      bus.wdata   = vecs[i].wdata;
      sb_q.push_back(vecs[i].exp_rdata);
      #3;
      chk($sformatf("vec%0d rdata", i), bus.rdata, sb_q.pop_front());
      step();
      chk($sformatf("vec%0d led_o", i), 32'(led_o), 32'(vecs[i].exp_led));
    end
    idle(1);

`ifdef IO_TIMER_EN
    // One-shot: count 3, ticks every 4 cycles
    wr(10'h024, 32'd3);
    wr(10'h020, 32'h1);
    idle(3);
    rd(10'h024, 32'd3, "oneshot count pre-tick");
    rd(10'h024, 32'd2, "oneshot count 2");
    idle(2);
    rd(10'h024, 32'd2, "oneshot count 2 late");
    rd(10'h024, 32'd1, "oneshot count 1");
    idle(2);
    rd(10'h024, 32'd1, "oneshot count at expiry");
    chk("oneshot irq set", 32'(timer_irq), 32'h1);
    rd(10'h020, 32'h0, "oneshot en cleared");
    rd(10'h024, 32'd0, "oneshot count zero");
    rd(10'h028, 32'h1, "oneshot tstat first");
    rd(10'h028, 32'h0, "oneshot tstat cleared");
    chk("oneshot irq cleared", 32'(timer_irq), 32'h0);
    idle(8);
    rd(10'h024, 32'd0, "oneshot stays stopped");

    // Auto-reload: count 2, expiry every 8 cycles
    wr(10'h024, 32'd2);
    wr(10'h020, 32'h3);
    idle(7);
    rd(10'h024, 32'd1, "auto count before expiry");
    chk("auto irq set", 32'(timer_irq), 32'h1);
    rd(10'h024, 32'd2, "auto reloaded");
    rd(10'h020, 32'h3, "auto en kept");
    rd(10'h028, 32'h1, "auto tstat read");
    chk("auto irq cleared", 32'(timer_irq), 32'h0);
    idle(4);
    rd(10'h028, 32'h0, "tstat read on expiry cycle");
    chk("set beats clear", 32'(timer_irq), 32'h1);
    rd(10'h024, 32'd2, "auto reloaded again");

    // Disable exactly on a tick cycle
    idle(2);
    wr(10'h020, 32'h2);
    rd(10'h024, 32'd2, "disable on tick no dec");
    rd(10'h020, 32'h2, "disable on tick ctrl");

    // TCOUNT load on a tick cycle wins, prescaler keeps its phase
    wr(10'h020, 32'h1);
    idle(3);
    wr(10'h024, 32'd9);
    rd(10'h024, 32'd9, "load on tick wins");
    idle(2);
    rd(10'h024, 32'd9, "load then next tick pre");
    rd(10'h024, 32'd8, "load then next tick dec");
    chk("irq before reset", 32'(timer_irq), 32'h1);
`else
    wr(10'h024, 32'd7);
    rd(10'h024, 32'h0, "no timer tcount");
    wr(10'h020, 32'h3);
    rd(10'h020, 32'h0, "no timer tctrl");
    rd(10'h028, 32'h0, "no timer tstat");
    idle(10);
    chk("no timer irq", 32'(timer_irq), 32'h0);
`endif

    // Reset mid-activity with a write strobe pending
    reset       = 1'b1;
    bus.iowrite = 1'b1;
    bus.addr    = 10'h060;
    bus.wdata   = 32'h00FFFFFF;
    step();
    reset       = 1'b0;
    bus.iowrite = 1'b0;
    chk("post reset led_o", 32'(led_o), 32'h0);
    chk("post reset irq", 32'(timer_irq), 32'h0);
    rd(10'h070, 32'h0, "post reset switch");
    rd(10'h060, 32'h0, "post reset led read");
    rd(10'h024, 32'h0, "post reset tcount");
    rd(10'h020, 32'h0, "post reset tctrl");
    rd(10'h028, 32'h0, "post reset tstat");
    idle(12);
    rd(10'h024, 32'h0, "post reset no ticks");
    chk("post reset irq stays", 32'(timer_irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
